ofs_plat_prim_sync_vector_qualified: RTL

// Parametrised successor to the slow-signal crossing register. Brings a

---
 rtl/ofs_plat_prim_sync_vector_qualified.sv | 105 ++++++++++
 1 files changed

// File: rtl/ofs_plat_prim_sync_vector_qualified.sv
// ofs_plat_prim_sync_vector_qualified
//
// Brings a slow, quasi-static WIDTH-bit vector from a foreign clock domain
// into clk. The vector passes through a SYNC_STAGES flop synchronizer. It is
// then qualified: a value is committed to sync_out only after raw_sync has
// matched the held candidate for STABLE_CYCLES consecutive cycles. Because of
// this, skewed multi-bit updates and short glitches never reach sync_out.
//
// Ports
//   clk         destination clock
//   reset       asynchronous, active-high reset
//   async_in    vector from the foreign domain
//   hold        1 = freeze sync_out and suppress commits; qualification still runs
//   raw_sync    last synchronizer stage, unqualified
//   sync_out    qualified vector
//   sync_valid  sticky, set by the first commit after reset
//   changed     one-cycle pulse on the cycle sync_out takes a new value
module ofs_plat_prim_sync_vector_qualified #(
  parameter int unsigned      WIDTH         = 1,
  parameter int unsigned      SYNC_STAGES   = 3,
  parameter int unsigned      STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  input  logic             hold,
  output logic [WIDTH-1:0] raw_sync,
  output logic [WIDTH-1:0] sync_out,
  output logic             sync_valid,
  output logic             changed
);

  localparam int unsigned      CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("STABLE_CYCLES must be >= 1");
  end

  // Synchronizer chain; kept intact so CDC constraints can find every stage.
  (* preserve *) logic [WIDTH-1:0] sync_chain [SYNC_STAGES];

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt;
  logic             commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= INITIAL_VALUE;
      end
    end else begin
      sync_chain[0] <= async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= sync_chain[i-1];
      end
    end
  end

  always_comb begin
    raw      = sync_chain[SYNC_STAGES-1];
    raw_sync = raw;
  end

  // Any bit difference against the candidate restarts qualification; the
  // counter saturates so a long-stable value keeps re-committing harmlessly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q <= INITIAL_VALUE;
      cnt    <= '0;
    end else if (raw != cand_q) begin
      cand_q <= raw;
      cnt    <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    commit = (raw == cand_q) && (cnt == CNT_MAX) && !hold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_out   <= INITIAL_VALUE;
      sync_valid <= 1'b0;
      changed    <= 1'b0;
    end else if (commit) begin
      sync_out   <= cand_q;
      sync_valid <= 1'b1;
      changed    <= (cand_q != sync_out);
    end else begin
      changed <= 1'b0;
    end
  end

endmodule
